// File: rtl/key_conditioner_pkg.sv
`default_nettype none
// key_conditioner_pkg: lane constants and types shared by the controller front end and judge stage.
package key_conditioner_pkg;

   localparam int N_LANES = 4;
   localparam int HOLD_W  = 16;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce_lane.sv
`default_nettype none
// key_debounce_lane: synchronise, debounce and time one raw lane button.
// Produces stable level, press/release pulses and a saturating hold counter.
module key_debounce_lane
   import key_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              key_raw,
   output logic              key_level,
   output logic              key_press,
   output logic              key_release,
   output logic [HOLD_W-1:0] hold_cnt
);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};

   logic              sync_meta;
   logic              sync_s;
   lane_state_t       state;
   lane_state_t       state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              press_nxt;
   logic              release_nxt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [HOLD_W-1:0] hold_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= key_raw;
         sync_s    <= sync_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RELEASED;
         cnt         <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         hold_cnt    <= hold_nxt;
      end
   end

   assign hold_inc = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_W'(1);

   // The counter only runs while the synchronised input disagrees with the
   // stable state; any agreeing cycle drops it back to zero.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = '0;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      hold_nxt    = '0;
      case (state)
         RELEASED: begin
            if (sync_s) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = PRESSED;
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         PRESSED: begin
            hold_nxt = hold_inc;
            if (!sync_s) begin
               if (cnt == CNT_LAST) begin
                  state_nxt   = RELEASED;
                  release_nxt = 1'b1;
                  hold_nxt    = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
      endcase
   end

   assign key_level = (state == PRESSED);

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// key_conditioner: four independent debounced lanes with packed hold counts
// and a "fresh" qualifier for the judging logic.
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int DB_CYCLES  = 500000,
   parameter int HOLD_LIMIT = 100000,
   parameter int CNT_W      = 20
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_LANES-1:0]        key_raw,
   output logic [N_LANES-1:0]        key_level,
   output logic [N_LANES-1:0]        key_press,
   output logic [N_LANES-1:0]        key_release,
   output logic [N_LANES-1:0]        key_fresh,
   output logic [N_LANES*HOLD_W-1:0] hold_cnt
);

   // Compared at 32 bits so limits beyond the hold counter range never expire.
   localparam logic [31:0] FRESH_LIMIT = 32'(HOLD_LIMIT);

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      logic [HOLD_W-1:0] lane_hold;

      key_debounce_lane #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .key_raw     (key_raw[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .hold_cnt    (lane_hold)
      );

      assign hold_cnt[i*HOLD_W +: HOLD_W] = lane_hold;
      assign key_fresh[i] = key_level[i] && (32'(lane_hold) < FRESH_LIMIT);
   end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// tb_key_conditioner: directed and randomized stimulus checked every cycle
// against a sample-window reference model of the four lanes.
module tb_key_conditioner;

   localparam int DB = 4;
   localparam int HL = 6;
   localparam int CW = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_raw = 4'b0000;
   logic [3:0]  key_level;
   logic [3:0]  key_press;
   logic [3:0]  key_release;
   logic [3:0]  key_fresh;
   logic [63:0] hold_cnt;

   key_conditioner #(
      .DB_CYCLES  (DB),
      .HOLD_LIMIT (HL),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_fresh   (key_fresh),
      .hold_cnt    (hold_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the level flips once the last DB synchronised samples
   // (raw delayed two edges) all differ from it; hold is the age since press.
   bit m_p1   [4];
   bit m_p2   [4];
   bit m_lvl  [4];
   bit m_press[4];
   bit m_rel  [4];
   bit m_win  [4][DB];
   int m_nsamp[4];
   int m_age  [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_p1[i] = 0; m_p2[i] = 0; m_lvl[i] = 0;
         m_press[i] = 0; m_rel[i] = 0; m_nsamp[i] = 0; m_age[i] = 0;
         for (int k = 0; k < DB; k++) m_win[i][k] = 0;
      end
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit samp;
      bit flip;
      for (int i = 0; i < 4; i++) begin
         samp    = m_p2[i];
         m_p2[i] = m_p1[i];
         m_p1[i] = r[i];
         for (int k = DB - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
         m_win[i][0] = samp;
         if (m_nsamp[i] < DB) m_nsamp[i]++;
         flip = (m_nsamp[i] >= DB);
         for (int k = 0; k < DB; k++) if (m_win[i][k] == m_lvl[i]) flip = 0;
         m_press[i] = flip && !m_lvl[i];
         m_rel[i]   = flip && m_lvl[i];
         if (flip) m_lvl[i] = !m_lvl[i];
         if (m_press[i])   m_age[i] = 0;
         else if (m_lvl[i]) m_age[i]++;
         else              m_age[i] = 0;
      end
   endtask

   function automatic int m_hold(input int i);
      if (!m_lvl[i]) return 0;
      return (m_age[i] > 65535) ? 65535 : m_age[i];
   endfunction

   task automatic compare_all();
      logic [3:0]  e_lvl, e_press, e_rel, e_fresh;
      logic [63:0] e_hold;
      for (int i = 0; i < 4; i++) begin
         e_lvl[i]   = m_lvl[i];
         e_press[i] = m_press[i];
         e_rel[i]   = m_rel[i];
         e_fresh[i] = m_lvl[i] && (m_hold(i) < HL);
         e_hold[i*16 +: 16] = 16'(m_hold(i));
      end
      check("level",   64'(key_level),   64'(e_lvl));
      check("press",   64'(key_press),   64'(e_press));
      check("release", 64'(key_release), 64'(e_rel));
      check("fresh",   64'(key_fresh),   64'(e_fresh));
      check("hold",    hold_cnt,         e_hold);
   endtask

   task automatic step(input logic [3:0] r);
      key_raw = r;
      @(posedge clk);
      model_edge(r);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int          k;
      logic        seen;
      int          run[4];
      logic [3:0]  cur;

      do_reset();
      check("reset_level", 64'(key_level), 64'd0);
      check("reset_hold",  hold_cnt,       64'd0);

      // Clean press on lane 0: level rises on the sixth edge.
      for (k = 1; k <= 20; k++) begin
         step(4'b0001);
         if (key_level[0]) break;
      end
      check("latency_press0", 64'(k), 64'd6);
      for (int j = 0; j < 10; j++) step(4'b0001);
      for (int j = 0; j < 10; j++) step(4'b0000);

      // Bounce on lane 1 must never be accepted.
      seen = 1'b0;
      for (int j = 0; j < 20; j++) begin
         step((j % 2 == 0) ? 4'b0010 : 4'b0000);
         seen |= key_level[1] | key_press[1] | key_release[1];
      end
      for (int j = 0; j < 10; j++) begin
         step(4'b0000);
         seen |= key_level[1] | key_press[1] | key_release[1];
      end
      check("bounce_lane1", 64'(seen), 64'd0);

      // Lane 2 held then released: release pulses six edges after the raw fall.
      for (int j = 0; j < 16; j++) step(4'b0100);
      for (k = 1; k <= 20; k++) begin
         step(4'b0000);
         if (key_release[2]) break;
      end
      check("latency_release2", 64'(k), 64'd6);
      check("hold2_after_release", 64'(hold_cnt[47:32]), 64'd0);
      for (int j = 0; j < 8; j++) step(4'b0000);

      // All lanes pressed together.
      for (int j = 0; j < 12; j++) step(4'b1111);
      for (int j = 0; j < 10; j++) step(4'b0000);

      // Reset while lane 0 is held with hold count 5, then re-detect.
      for (k = 0; k < 30 && m_hold(0) != 5; k++) step(4'b0001);
      check("hold0_before_reset", 64'(hold_cnt[15:0]), 64'd5);
      do_reset();
      for (k = 1; k <= 20; k++) begin
         step(4'b0001);
         if (key_press[0]) break;
      end
      check("latency_repress0", 64'(k), 64'd6);
      check("hold0_restart", 64'(hold_cnt[15:0]), 64'd0);
      for (int j = 0; j < 10; j++) step(4'b0000);

      // Random per-lane run lengths mix short glitches and accepted presses.
      for (int i = 0; i < 4; i++) run[i] = 0;
      cur = 4'b0000;
      for (int j = 0; j < 2000; j++) begin
         for (int i = 0; i < 4; i++) begin
            if (run[i] == 0) begin
               cur[i] = 1'($urandom_range(0, 1));
               run[i] = int'($urandom_range(1, 9));
            end
            run[i]--;
         end
         step(cur);
      end
      for (int j = 0; j < 10; j++) step(4'b0000);

      // Long hold on lane 3 saturates the counter without wrapping.
      for (int j = 0; j < 70000; j++) step(4'b1000);
      check("sat_hold3",  64'(hold_cnt[63:48]), 64'h0000_0000_0000_FFFF);
      check("sat_fresh3", 64'(key_fresh[3]),    64'd0);
      for (int j = 0; j < 10; j++) step(4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
